// File: rtl/hex_pager.sv
// hex_pager: shows a 32-bit debug word on four active-low seven-segment
// digits. The upper and lower halfwords take turns on a page timer. HOLD
// freezes the captured word, and CHANGED pulses when the captured word changes.
module hex_pager #(
  parameter int PAGE_CYCLES = 50000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DIN,
  input  logic [9:0]  SEL,
  input  logic        HOLD,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        PAGE,
  output logic        CHANGED
);

  localparam int unsigned TW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(PAGE_CYCLES - 1);

  typedef enum logic {
    PG_UPPER = 1'b0,
    PG_LOWER = 1'b1
  } page_e;

  logic [31:0]      val_q, val_d;
  logic [9:0]       sel_q, sel_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  page_e            page_q, page_d;
  logic [3:0][6:0]  hex_q, hex_d;
  logic             changed_q, changed_d;

  logic        sel_valid, sel_chg, capture, shown_valid;
  logic [15:0] shown;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state logic for capture, the page timer and the registered digit decode.
  always_comb begin
    val_d     = val_q;
    sel_d     = SEL;
    tmr_d     = tmr_q;
    page_d    = page_q;
    changed_d = 1'b0;
    hex_d     = '1;

    sel_valid = $onehot(SEL);
    sel_chg   = (SEL != sel_q);
    capture   = !HOLD || sel_chg;

    if (capture) begin
      val_d     = DIN;
      changed_d = (DIN != val_q);
    end

    if (sel_chg || !sel_valid) begin
      tmr_d  = '0;
      page_d = PG_UPPER;
    end else if (tmr_q == TMR_LAST) begin
      tmr_d  = '0;
      page_d = page_e'(~page_q);
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    // The decode runs one stage behind VAL/PAGE. Blanking therefore keys
    // off the registered select, so it lines up with the word it gates.
    shown_valid = $onehot(sel_q);
    shown       = (page_q == PG_LOWER) ? val_q[15:0] : val_q[31:16];
    for (int unsigned i = 0; i < 4; i++) begin
      hex_d[i] = shown_valid ? seg7(shown[4*i +: 4]) : '1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      val_q     <= '0;
      sel_q     <= '0;
      tmr_q     <= '0;
      page_q    <= PG_UPPER;
      hex_q     <= '1;
      changed_q <= 1'b0;
    end else begin
      val_q     <= val_d;
      sel_q     <= sel_d;
      tmr_q     <= tmr_d;
      page_q    <= page_d;
      hex_q     <= hex_d;
      changed_q <= changed_d;
    end
  end

  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign PAGE    = (page_q == PG_LOWER);
  assign CHANGED = changed_q;

endmodule

// File: doc/hex_pager.md
Name: hex_pager

Overview:
- Display-side consumer of the debug-value selector. The selector produces a 32-bit debug word (DIN) and a one-hot select vector (LEDR); this block renders that word on four active-low seven-segment digits (HEX3..HEX0).
- A 32-bit word needs 8 hex digits but only 4 are available, so the block pages between the upper and lower halfword on a timer.
- It also provides a freeze (HOLD) input and a change-indicator pulse.

Parameters:
- PAGE_CYCLES, 50000000, clock cycles per page (1 s at 50 MHz); legal range >= 2. Counter width is clog2(PAGE_CYCLES).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  32  debug word from the selector.
- SEL  input  10  one-hot select vector from the selector (its LEDR output).
- HOLD  input  1  1 = freeze the captured word.
- HEX0  output  7  digit 0 (rightmost), segments gfedcba, active-low.
- HEX1  output  7  digit 1.
- HEX2  output  7  digit 2.
- HEX3  output  7  digit 3 (leftmost).
- PAGE  output  1  0 = upper half VAL[31:16] shown, 1 = lower half VAL[15:0] shown.
- CHANGED  output  1  one-cycle pulse when the captured word takes a new, different value.

Behaviour:
- Registers: VAL[31:0] (captured word), SEL_q[9:0], TMR (page counter), PAGE, HEX0..HEX3, CHANGED.
- Reset (RST=1 at posedge): VAL=0, SEL_q=0, TMR=0, PAGE=0, HEX0..3=7'h7F (all segments off), CHANGED=0. Reset mid-page discards the current page and timer.
- Definitions:
  - sel_valid = SEL has exactly one bit set.
  - sel_chg = (SEL != SEL_q).
  - SEL_q <= SEL every cycle.
- Capture: VAL <= DIN when (HOLD=0) or sel_chg. A select change always forces a capture, even under HOLD. Otherwise VAL holds.
- CHANGED <= 1 for exactly one cycle when a capture occurs and DIN != VAL; otherwise 0.
- Page timer, in priority order:
  1. If sel_chg or !sel_valid: TMR <= 0, PAGE <= 0.
  2. Else if TMR == PAGE_CYCLES-1: TMR <= 0, PAGE <= ~PAGE.
  3. Else: TMR <= TMR+1.
  - A select change in the same cycle as timer terminal count follows rule 1: the page does not toggle.
- Digit mapping, using post-update VAL/PAGE (registered decode):
  - PAGE=0: HEX3..HEX0 = nibbles VAL[31:28], VAL[27:24], VAL[23:20], VAL[19:16].
  - PAGE=1: HEX3..HEX0 = nibbles VAL[15:12], VAL[11:8], VAL[7:4], VAL[3:0].
  - HEX outputs update one cycle after the VAL/PAGE update, so DIN-to-HEX latency is 2 cycles.
- Segment table (hex nibble -> 7-bit code):
  - 0->40, 1->79, 2->24, 3->30
  - 4->19, 5->12, 6->02, 7->78
  - 8->00, 9->10, A->08, b->03
  - C->46, d->21, E->06, F->0E
- Invalid select: when sel_valid=0 (SEL zero or multi-hot), all HEX <= 7'h7F. VAL capture is still governed by the capture rule.
- Leading zeros are displayed; there is no blanking.
- All outputs are registered, with no combinational paths from inputs to outputs.

Test Plan:
1. Reset and first page (PAGE_CYCLES=4): RST high for 2 cycles, then SEL=1, DIN=32'h1234ABCD, HOLD=0.
   - During reset: HEX=7F.
   - 2 cycles after release: HEX3..0=79,24,30,19 ("1234"), PAGE=0.
   - PAGE toggles to 1 after 4 cycles; HEX shows 08,03,46,21 ("AbCd").
   - Pages then alternate every 4 cycles.
2. Select change resets the page: while PAGE=1, set SEL 1->2 with DIN=32'h00000010.
   - Next cycle: PAGE=0, TMR=0, CHANGED=1 for 1 cycle.
   - HEX shows 40,40,40,40, then after 4 cycles 40,40,79,40.
3. HOLD freeze: set HOLD=1, then change DIN to 32'hFFFFFFFF with SEL constant.
   - Display keeps the prior VAL; CHANGED stays 0.
   - Then change SEL 2->4 while HOLD=1: VAL captures FFFFFFFF, HEX shows 0E x4, CHANGED pulses once.
4. Simultaneous events: assert a SEL change on the exact cycle TMR==PAGE_CYCLES-1.
   - PAGE=0, TMR=0 next cycle; no toggle.
5. Invalid select: drive SEL=0, then SEL=10'b0000000011.
   - HEX=7F on all digits, PAGE held at 0, TMR held at 0.
   - Restore SEL=8: display resumes from page 0 after 2 cycles.
6. Reset mid-operation: assert RST while PAGE=1 and TMR=2.
   - Next cycle: PAGE=0, TMR=0, VAL=0, HEX=7F, CHANGED=0.
